ddr_port_arbiter: RTL and testbench
===================================

Name: ddr_port_arbiter

Overview:
Schedules the single DDR MCB command port between two requesters: the ADC capture writer (WRITE bursts) and the USB readback reader (READ bursts). It issues a command only when the MCB data FIFO for that direction can sustain a full burst, so write underrun and read overflow cannot occur. Writes have fixed priority, bounded by a read-starvation limit. Sits in the ddr_usrclk domain, between the capture/readback sequencers and the MCB user port.

Parameters:
BL_WORDS, 64, burst length in 32-bit words; cmd_bl_o = BL_WORDS-1
FIFO_DEPTH, 64, MCB read-data FIFO depth in words
ADDR_W, 30, MCB byte-address width
STARVE_MAX, 8, consecutive write grants allowed while a read is eligible
CNT_W, 16, width of command statistics counters

Ports:
ddr_usrclk  in  1  block clock, MCB user clock
reset_i  in  1  synchronous, active-high reset
calib_done_i  in  1  MCB calibration complete
wr_req_i  in  1  capture writer requests a WRITE burst
wr_addr_i  in  ADDR_W  byte address of the write burst
wr_fifo_count_i  in  7  MCB write-data FIFO word count
wr_gnt_o  out  1  one-cycle pulse: write command issued
rd_req_i  in  1  readback requests a READ burst
rd_addr_i  in  ADDR_W  byte address of the read burst
rd_fifo_count_i  in  7  MCB read-data FIFO word count
rd_gnt_o  out  1  one-cycle pulse: read command issued
cmd_full_i  in  1  MCB command FIFO full
cmd_en_o  out  1  MCB command strobe
cmd_instr_o  out  3  000 WRITE, 001 READ
cmd_bl_o  out  6  constant BL_WORDS-1
cmd_byte_addr_o  out  ADDR_W  command address
busy_o  out  1  state is not IDLE or ARB
err_align_o  out  1  sticky: a misaligned request was seen
wr_cmds_o  out  CNT_W  issued WRITE count, wraps
rd_cmds_o  out  CNT_W  issued READ count, wraps

Behaviour:
- Reset (synchronous): state=IDLE. All outputs 0, except cmd_bl_o, which is constant. Counters, the starvation counter and err_align_o are cleared.
- Alignment: an address is aligned when addr[log2(BL_WORDS*4)-1:0]==0, i.e. bits [7:0] at the default BL_WORDS.
  - A misaligned request is never eligible and sets err_align_o; only reset clears it.
- wr_elig = wr_req_i & aligned(wr_addr_i) & (wr_fifo_count_i >= BL_WORDS).
- rd_elig = rd_req_i & aligned(rd_addr_i) & (FIFO_DEPTH - rd_fifo_count_i >= BL_WORDS).
- IDLE: wait for calib_done_i=1, then go to ARB.
- ARB:
  - If only one requester is eligible, take it.
  - If both are eligible: take write, unless starve_cnt==STARVE_MAX, in which case take read.
  - Latch instr and address into the command registers, then go to ISSUE. If neither is eligible, stay in ARB.
- ISSUE:
  - If cmd_full_i=0: on the next edge, cmd_en_o=1 for exactly one cycle, plus the matching gnt pulse in the same cycle. Increment that direction's counter. Go to GAP.
  - If cmd_full_i=1: hold in ISSUE and keep the command registers stable.
- GAP: exactly one cycle, so the requester can drop req or advance its address and the FIFO counts can settle. Then go to ARB.
- Latency: eligible in ARB at edge T, cmd_full_i low at T+1, gives cmd_en_o high in the cycle after T+1. Back-to-back commands are at least 3 cycles apart.
- Starvation counter:
  - Increments on a write grant made while rd_elig=1, saturating at STARVE_MAX.
  - Clears on any read grant.
  - Clears on a write grant made while rd_elig=0.
- Commitment: once latched in ARB, the command is issued even if req falls before the grant.
  - Requesters hold req and addr stable until gnt.
  - gnt pulses only in the cycle cmd_en_o is high.
- calib_done_i falling in any state:
  - Go to IDLE on the next edge.
  - Discard the latched command: no cmd_en_o, no gnt.
  - Starvation counter cleared; statistics counters kept.
- cmd_byte_addr_o and cmd_instr_o change only on ARB→ISSUE and are valid whenever cmd_en_o=1.
- Simultaneous cmd_full_i rising in the ISSUE cycle: the command is not issued and the block waits.

Decomposition:
- Package ddr_arb_pkg holds:
  - the state encoding (IDLE, ARB, ISSUE, GAP);
  - the instruction constants INSTR_WRITE=3'b000 and INSTR_READ=3'b001;
  - the default BL_WORDS and the alignment-mask function.
- One sub-module, ddr_arb_prio: combinational eligibility evaluation plus the starvation counter. It outputs the grant selection. The top level holds the FSM, command registers and statistics counters.

Test Plan:
- Calibration gating: calib_done_i=0, wr_req_i=1, addr 0x100, wr_fifo_count_i=64 → no cmd_en_o. Raise calib_done_i → one cmd_en_o, instr 000, addr 0x100, bl 63, wr_gnt_o coincident, wr_cmds_o=1.
- FIFO gating:
  - wr_fifo_count_i=63 → no write grant; raise it to 64 → grant.
  - rd_fifo_count_i=1 → no read grant; drop it to 0 → read at rd_addr_i 0x200, instr 001.
- Starvation: both eligible continuously with STARVE_MAX=8 → grants W×8, R, W×8, R. Every cmd_en_o is at least 3 cycles apart.
- Backpressure: cmd_full_i=1 for 10 cycles during ISSUE → cmd_en_o stays 0 and address stays stable. Release → single cmd_en_o and single gnt.
- Misalignment: wr_addr_i=0x104 → never granted, err_align_o=1 and stays 1 after the request is withdrawn. Only reset_i clears it.
- Abort and reset:
  - calib_done_i drops in ISSUE with cmd_full_i=1 → no cmd_en_o, state IDLE.
  - reset_i pulse mid-ISSUE → all outputs 0 on the next edge, counters 0.

Source files
------------

// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the DDR command-port arbiter: FSM states,
// MCB instruction codes and the burst alignment helper.
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_t;

    localparam logic [2:0] INSTR_WRITE = 3'b000;
    localparam logic [2:0] INSTR_READ  = 3'b001;

    localparam int DEF_BL_WORDS = 64;

    // Mask of the byte-address bits that must be zero for a burst of
    // bl_words 32-bit words to start on its own natural boundary.
    function automatic logic [63:0] align_mask(input int bl_words);
        return (64'd1 << $clog2(bl_words * 4)) - 64'd1;
    endfunction

endpackage

// File: rtl/ddr_arb_prio.sv
// Eligibility evaluation for the write and read requesters plus the
// read-starvation counter; produces a mutually exclusive grant selection.
module ddr_arb_prio
    import ddr_arb_pkg::*;
#(
    parameter int BL_WORDS   = DEF_BL_WORDS,
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_W     = 30,
    parameter int STARVE_MAX = 8
) (
    input  logic              ddr_usrclk,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              arb_i,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [6:0]        wr_fifo_count_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [6:0]        rd_fifo_count_i,
    output logic              sel_wr_o,
    output logic              sel_rd_o,
    output logic              misalign_o
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(BL_WORDS));
    localparam int                SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);

    logic          w_wr_aligned;
    logic          w_rd_aligned;
    logic          w_wr_elig;
    logic          w_rd_elig;
    logic          w_starved;
    logic [SW-1:0] r_starve_cnt;

    assign w_wr_aligned = (wr_addr_i & ALIGN_MASK) == '0;
    assign w_rd_aligned = (rd_addr_i & ALIGN_MASK) == '0;

    // A write needs a full burst already queued; a read needs room for one.
    assign w_wr_elig = wr_req_i && w_wr_aligned
                       && (int'(wr_fifo_count_i) >= BL_WORDS);
    assign w_rd_elig = rd_req_i && w_rd_aligned
                       && ((FIFO_DEPTH - int'(rd_fifo_count_i)) >= BL_WORDS);

    assign w_starved  = (r_starve_cnt == STARVE_LIM);
    assign sel_wr_o   = w_wr_elig && (!w_rd_elig || !w_starved);
    assign sel_rd_o   = w_rd_elig && (!w_wr_elig || w_starved);
    assign misalign_o = (wr_req_i && !w_wr_aligned) || (rd_req_i && !w_rd_aligned);

    // Count write grants taken while a read was waiting; any read grant or an
    // uncontested write grant resets the count.
    always_ff @(posedge ddr_usrclk) begin
        if (reset_i || clear_i) begin
            r_starve_cnt <= '0;
        end else if (arb_i && sel_rd_o) begin
            r_starve_cnt <= '0;
        end else if (arb_i && sel_wr_o) begin
            if (!w_rd_elig) begin
                r_starve_cnt <= '0;
            end else if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Schedules the single MCB command port between the capture writer and the
// readback reader; a command is issued only when its data FIFO can take a
// full burst.
module ddr_port_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int BL_WORDS   = DEF_BL_WORDS,
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_W     = 30,
    parameter int STARVE_MAX = 8,
    parameter int CNT_W      = 16
) (
    input  logic              ddr_usrclk,
    input  logic              reset_i,
    input  logic              calib_done_i,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [6:0]        wr_fifo_count_i,
    output logic              wr_gnt_o,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [6:0]        rd_fifo_count_i,
    output logic              rd_gnt_o,
    input  logic              cmd_full_i,
    output logic              cmd_en_o,
    output logic [2:0]        cmd_instr_o,
    output logic [5:0]        cmd_bl_o,
    output logic [ADDR_W-1:0] cmd_byte_addr_o,
    output logic              busy_o,
    output logic              err_align_o,
    output logic [CNT_W-1:0]  wr_cmds_o,
    output logic [CNT_W-1:0]  rd_cmds_o
);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              w_latch;
    logic              w_issue;
    logic              w_sel_wr;
    logic              w_sel_rd;
    logic              w_misalign;
    logic              w_arb;
    logic              r_cmd_en;
    logic              r_wr_gnt;
    logic              r_rd_gnt;
    logic              r_err_align;
    logic [2:0]        r_cmd_instr;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [CNT_W-1:0]  r_wr_cmds;
    logic [CNT_W-1:0]  r_rd_cmds;

    assign w_arb = (r_state == ST_ARB) && calib_done_i;

    ddr_arb_prio #(
        .BL_WORDS   (BL_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .ddr_usrclk      (ddr_usrclk),
        .reset_i         (reset_i),
        .clear_i         (!calib_done_i),
        .arb_i           (w_arb),
        .wr_req_i        (wr_req_i),
        .wr_addr_i       (wr_addr_i),
        .wr_fifo_count_i (wr_fifo_count_i),
        .rd_req_i        (rd_req_i),
        .rd_addr_i       (rd_addr_i),
        .rd_fifo_count_i (rd_fifo_count_i),
        .sel_wr_o        (w_sel_wr),
        .sel_rd_o        (w_sel_rd),
        .misalign_o      (w_misalign)
    );

    // State register.
    always_ff @(posedge ddr_usrclk) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state; losing calibration aborts whatever is in flight.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_issue      = 1'b0;
        if (!calib_done_i) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_next = ST_ARB;
                ST_ARB: begin
                    if (w_sel_wr || w_sel_rd) begin
                        w_latch      = 1'b1;
                        w_state_next = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!cmd_full_i) begin
                        w_issue      = 1'b1;
                        w_state_next = ST_GAP;
                    end
                end
                ST_GAP:  w_state_next = ST_ARB;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Command registers change only when a request is committed in ARB.
    always_ff @(posedge ddr_usrclk) begin
        if (reset_i) begin
            r_cmd_instr <= INSTR_WRITE;
            r_cmd_addr  <= '0;
        end else if (w_latch) begin
            r_cmd_instr <= w_sel_wr ? INSTR_WRITE : INSTR_READ;
            r_cmd_addr  <= w_sel_wr ? wr_addr_i : rd_addr_i;
        end
    end

    // Command strobe, grant pulses and per-direction statistics.
    always_ff @(posedge ddr_usrclk) begin
        if (reset_i) begin
            r_cmd_en  <= 1'b0;
            r_wr_gnt  <= 1'b0;
            r_rd_gnt  <= 1'b0;
            r_wr_cmds <= '0;
            r_rd_cmds <= '0;
        end else begin
            r_cmd_en <= w_issue;
            r_wr_gnt <= w_issue && (r_cmd_instr == INSTR_WRITE);
            r_rd_gnt <= w_issue && (r_cmd_instr == INSTR_READ);
            if (w_issue && (r_cmd_instr == INSTR_WRITE)) begin
                r_wr_cmds <= r_wr_cmds + CNT_W'(1);
            end
            if (w_issue && (r_cmd_instr == INSTR_READ)) begin
                r_rd_cmds <= r_rd_cmds + CNT_W'(1);
            end
        end
    end

    // Sticky flag for any misaligned request; only reset clears it.
    always_ff @(posedge ddr_usrclk) begin
        if (reset_i) begin
            r_err_align <= 1'b0;
        end else if (w_misalign) begin
            r_err_align <= 1'b1;
        end
    end

    assign cmd_en_o        = r_cmd_en;
    assign wr_gnt_o        = r_wr_gnt;
    assign rd_gnt_o        = r_rd_gnt;
    assign cmd_instr_o     = r_cmd_instr;
    assign cmd_byte_addr_o = r_cmd_addr;
    assign cmd_bl_o        = 6'(BL_WORDS - 1);
    assign busy_o          = (r_state == ST_ISSUE) || (r_state == ST_GAP);
    assign err_align_o     = r_err_align;
    assign wr_cmds_o       = r_wr_cmds;
    assign rd_cmds_o       = r_rd_cmds;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Self-checking bench for ddr_port_arbiter: scenario tasks with randomized
// addresses and FIFO levels, checked against expectations derived from the
// arbitration rules.
module tb_ddr_port_arbiter;

    localparam int BL_WORDS   = 64;
    localparam int FIFO_DEPTH = 64;
    localparam int ADDR_W     = 30;
    localparam int STARVE_MAX = 8;
    localparam int CNT_W      = 16;

    logic              ddr_usrclk = 1'b0;
    logic              reset_i;
    logic              calib_done_i;
    logic              wr_req_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [6:0]        wr_fifo_count_i;
    logic              wr_gnt_o;
    logic              rd_req_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic [6:0]        rd_fifo_count_i;
    logic              rd_gnt_o;
    logic              cmd_full_i;
    logic              cmd_en_o;
    logic [2:0]        cmd_instr_o;
    logic [5:0]        cmd_bl_o;
    logic [ADDR_W-1:0] cmd_byte_addr_o;
    logic              busy_o;
    logic              err_align_o;
    logic [CNT_W-1:0]  wr_cmds_o;
    logic [CNT_W-1:0]  rd_cmds_o;

    typedef struct {
        int                cyc;
        logic [2:0]        instr;
        logic [ADDR_W-1:0] addr;
        logic              wg;
        logic              rg;
        logic [5:0]        bl;
    } ev_t;

    ev_t               evq[$];
    ev_t               mon_e;
    int                cyc     = 0;
    int                stray   = 0;
    int                n_pass  = 0;
    int                n_total = 0;
    int                wr_mode;
    int                rd_mode;
    int                wr_k;
    int                rd_k;
    logic [ADDR_W-1:0] wr_list [32];
    logic [ADDR_W-1:0] rd_list [32];

    ddr_port_arbiter #(
        .BL_WORDS   (BL_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) dut (
        .ddr_usrclk      (ddr_usrclk),
        .reset_i         (reset_i),
        .calib_done_i    (calib_done_i),
        .wr_req_i        (wr_req_i),
        .wr_addr_i       (wr_addr_i),
        .wr_fifo_count_i (wr_fifo_count_i),
        .wr_gnt_o        (wr_gnt_o),
        .rd_req_i        (rd_req_i),
        .rd_addr_i       (rd_addr_i),
        .rd_fifo_count_i (rd_fifo_count_i),
        .rd_gnt_o        (rd_gnt_o),
        .cmd_full_i      (cmd_full_i),
        .cmd_en_o        (cmd_en_o),
        .cmd_instr_o     (cmd_instr_o),
        .cmd_bl_o        (cmd_bl_o),
        .cmd_byte_addr_o (cmd_byte_addr_o),
        .busy_o          (busy_o),
        .err_align_o     (err_align_o),
        .wr_cmds_o       (wr_cmds_o),
        .rd_cmds_o       (rd_cmds_o)
    );

    always #5 ddr_usrclk = ~ddr_usrclk;

    // Cycle counter.
    always @(posedge ddr_usrclk) cyc <= cyc + 1;

    // Record every issued command; note grant pulses without a command.
    always @(negedge ddr_usrclk) begin
        if (cmd_en_o === 1'b1) begin
            mon_e.cyc   = cyc;
            mon_e.instr = cmd_instr_o;
            mon_e.addr  = cmd_byte_addr_o;
            mon_e.wg    = wr_gnt_o;
            mon_e.rg    = rd_gnt_o;
            mon_e.bl    = cmd_bl_o;
            evq.push_back(mon_e);
            $display("cmd cyc=%0d instr=%03b addr=0x%08h bl=%0d wr_gnt=%0b rd_gnt=%0b",
                     cyc, cmd_instr_o, cmd_byte_addr_o, cmd_bl_o, wr_gnt_o, rd_gnt_o);
        end else if (wr_gnt_o === 1'b1 || rd_gnt_o === 1'b1) begin
            stray++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [ADDR_W-1:0] rand_aligned();
        logic [ADDR_W-1:0] a;
        a      = ADDR_W'($urandom());
        a[7:0] = 8'h00;
        return a;
    endfunction

    // One cycle; requesters react to their grant (drop req or advance addr).
    task automatic tick();
        @(negedge ddr_usrclk);
        #1;
        if (wr_gnt_o === 1'b1) begin
            if (wr_mode == 0) wr_req_i = 1'b0;
            else begin wr_k++; wr_addr_i = wr_list[wr_k % 32]; end
        end
        if (rd_gnt_o === 1'b1) begin
            if (rd_mode == 0) rd_req_i = 1'b0;
            else begin rd_k++; rd_addr_i = rd_list[rd_k % 32]; end
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1; calib_done_i = 1'b0; cmd_full_i = 1'b0;
        wr_req_i = 1'b0; wr_addr_i = '0; wr_fifo_count_i = 7'd0;
        rd_req_i = 1'b0; rd_addr_i = '0; rd_fifo_count_i = 7'd64;
        wr_mode = 0; rd_mode = 0;
        repeat (2) tick();
        reset_i = 1'b0;
        tick();
        evq.delete(); stray = 0; wr_k = 0; rd_k = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (cmd_en_o !== 1'b0) $display("FAIL reset_cmd_en: got %0b want 0", cmd_en_o); else n_pass++;
        n_total++; if (wr_gnt_o !== 1'b0) $display("FAIL reset_wr_gnt: got %0b want 0", wr_gnt_o); else n_pass++;
        n_total++; if (rd_gnt_o !== 1'b0) $display("FAIL reset_rd_gnt: got %0b want 0", rd_gnt_o); else n_pass++;
        n_total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy_o); else n_pass++;
        n_total++; if (err_align_o !== 1'b0) $display("FAIL reset_err: got %0b want 0", err_align_o); else n_pass++;
        n_total++; if (wr_cmds_o !== '0) $display("FAIL reset_wr_cmds: got %0d want 0", wr_cmds_o); else n_pass++;
        n_total++; if (rd_cmds_o !== '0) $display("FAIL reset_rd_cmds: got %0d want 0", rd_cmds_o); else n_pass++;
        n_total++; if (cmd_instr_o !== 3'b000) $display("FAIL reset_instr: got %03b want 000", cmd_instr_o); else n_pass++;
        n_total++; if (cmd_byte_addr_o !== '0) $display("FAIL reset_addr: got 0x%0h want 0", cmd_byte_addr_o); else n_pass++;
        n_total++; if (cmd_bl_o !== 6'(BL_WORDS - 1)) $display("FAIL reset_bl: got %0d want %0d", cmd_bl_o, BL_WORDS - 1); else n_pass++;
    endtask

    task automatic test_calib_gating();
        int k0;
        do_reset();
        wr_addr_i = 30'h100; wr_fifo_count_i = 7'd64; wr_req_i = 1'b1;
        repeat (10) tick();
        n_total++; if (evq.size() != 0) $display("FAIL calib_hold: got %0d cmds want 0", evq.size()); else n_pass++;
        k0 = cyc;
        calib_done_i = 1'b1;
        for (int i = 0; i < 20 && evq.size() == 0; i++) tick();
        repeat (6) tick();
        n_total++; if (evq.size() != 1) $display("FAIL calib_cmd_count: got %0d want 1", evq.size()); else n_pass++;
        if (evq.size() > 0) begin
            n_total++; if (evq[0].instr !== 3'b000) $display("FAIL calib_instr: got %03b want 000", evq[0].instr); else n_pass++;
            n_total++; if (evq[0].addr !== 30'h100) $display("FAIL calib_addr: got 0x%0h want 0x100", evq[0].addr); else n_pass++;
            n_total++; if (evq[0].bl !== 6'd63) $display("FAIL calib_bl: got %0d want 63", evq[0].bl); else n_pass++;
            n_total++; if (evq[0].wg !== 1'b1 || evq[0].rg !== 1'b0) $display("FAIL calib_gnt: got wr=%0b rd=%0b want wr=1 rd=0", evq[0].wg, evq[0].rg); else n_pass++;
            n_total++; if (evq[0].cyc - k0 != 3) $display("FAIL calib_latency: got %0d want 3", evq[0].cyc - k0); else n_pass++;
        end
        n_total++; if (wr_cmds_o !== 16'd1) $display("FAIL calib_wr_cmds: got %0d want 1", wr_cmds_o); else n_pass++;
        n_total++; if (stray != 0) $display("FAIL calib_stray_gnt: got %0d want 0", stray); else n_pass++;
    endtask

    task automatic test_fifo_gating();
        int cnt, exp_n, n0;
        logic [ADDR_W-1:0] a;
        do_reset();
        calib_done_i = 1'b1;
        repeat (2) tick();
        for (int t = 0; t < 5; t++) begin
            cnt   = (t == 0) ? 63 : int'($urandom_range(0, 127));
            exp_n = (cnt >= BL_WORDS) ? 1 : 0;
            n0    = evq.size();
            a     = rand_aligned();
            wr_addr_i = a; wr_fifo_count_i = 7'(cnt); wr_req_i = 1'b1;
            repeat (12) tick();
            n_total++; if (evq.size() - n0 != exp_n) $display("FAIL wr_fifo_gate count=%0d: got %0d cmds want %0d", cnt, evq.size() - n0, exp_n); else n_pass++;
            if (exp_n == 0) begin
                wr_fifo_count_i = 7'd64;
                repeat (12) tick();
                n_total++; if (evq.size() - n0 != 1) $display("FAIL wr_fifo_release: got %0d cmds want 1", evq.size() - n0); else n_pass++;
            end
            if (evq.size() > n0) begin
                n_total++; if (evq[n0].instr !== 3'b000 || evq[n0].addr !== a) $display("FAIL wr_fifo_cmd: got %03b/0x%0h want 000/0x%0h", evq[n0].instr, evq[n0].addr, a); else n_pass++;
            end
            wr_req_i = 1'b0;
            tick();
        end
        for (int t = 0; t < 5; t++) begin
            cnt   = (t == 0) ? 1 : int'($urandom_range(0, 127));
            exp_n = ((FIFO_DEPTH - cnt) >= BL_WORDS) ? 1 : 0;
            n0    = evq.size();
            a     = (t == 0) ? 30'h200 : rand_aligned();
            rd_addr_i = a; rd_fifo_count_i = 7'(cnt); rd_req_i = 1'b1;
            repeat (12) tick();
            n_total++; if (evq.size() - n0 != exp_n) $display("FAIL rd_fifo_gate count=%0d: got %0d cmds want %0d", cnt, evq.size() - n0, exp_n); else n_pass++;
            if (exp_n == 0) begin
                rd_fifo_count_i = 7'd0;
                repeat (12) tick();
                n_total++; if (evq.size() - n0 != 1) $display("FAIL rd_fifo_release: got %0d cmds want 1", evq.size() - n0); else n_pass++;
            end
            if (evq.size() > n0) begin
                n_total++; if (evq[n0].instr !== 3'b001 || evq[n0].addr !== a || evq[n0].rg !== 1'b1) $display("FAIL rd_fifo_cmd: got %03b/0x%0h/gnt %0b want 001/0x%0h/1", evq[n0].instr, evq[n0].addr, evq[n0].rg, a); else n_pass++;
            end
            rd_req_i = 1'b0;
            tick();
        end
    endtask

    task automatic test_starvation();
        int st, wi, ri;
        logic              exp_w;
        logic [ADDR_W-1:0] exp_a;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            wr_list[i] = rand_aligned();
            rd_list[i] = rand_aligned();
        end
        wr_addr_i = wr_list[0]; rd_addr_i = rd_list[0];
        wr_fifo_count_i = 7'd64; rd_fifo_count_i = 7'd0;
        wr_mode = 1; rd_mode = 1;
        wr_req_i = 1'b1; rd_req_i = 1'b1; calib_done_i = 1'b1;
        for (int i = 0; i < 300 && evq.size() < 18; i++) tick();
        n_total++; if (evq.size() != 18) $display("FAIL starve_count: got %0d cmds want 18", evq.size()); else n_pass++;
        n_total++; if (wr_cmds_o !== 16'd16 || rd_cmds_o !== 16'd2) $display("FAIL starve_stats: got wr=%0d rd=%0d want wr=16 rd=2", wr_cmds_o, rd_cmds_o); else n_pass++;
        wr_req_i = 1'b0; rd_req_i = 1'b0;
        st = 0; wi = 0; ri = 0;
        for (int n = 0; n < 18 && n < evq.size(); n++) begin
            if (st == STARVE_MAX) begin
                exp_w = 1'b0; st = 0; exp_a = rd_list[ri]; ri++;
            end else begin
                exp_w = 1'b1; st++; exp_a = wr_list[wi]; wi++;
            end
            n_total++; if (evq[n].instr !== (exp_w ? 3'b000 : 3'b001) || evq[n].wg !== exp_w || evq[n].rg !== !exp_w) $display("FAIL starve_order[%0d]: got instr %03b wg %0b rg %0b want write=%0b", n, evq[n].instr, evq[n].wg, evq[n].rg, exp_w); else n_pass++;
            n_total++; if (evq[n].addr !== exp_a) $display("FAIL starve_addr[%0d]: got 0x%0h want 0x%0h", n, evq[n].addr, exp_a); else n_pass++;
            if (n > 0) begin
                n_total++; if (evq[n].cyc - evq[n-1].cyc < 3) $display("FAIL starve_spacing[%0d]: got %0d cycles want >=3", n, evq[n].cyc - evq[n-1].cyc); else n_pass++;
            end
        end
        repeat (8) tick();
    endtask

    task automatic test_backpressure();
        int bad;
        logic [ADDR_W-1:0] a;
        do_reset();
        a = rand_aligned();
        wr_addr_i = a; wr_fifo_count_i = 7'd64; wr_req_i = 1'b1;
        cmd_full_i = 1'b1; calib_done_i = 1'b1;
        repeat (4) tick();
        n_total++; if (busy_o !== 1'b1) $display("FAIL bp_busy: got %0b want 1", busy_o); else n_pass++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cmd_byte_addr_o !== a || cmd_instr_o !== 3'b000 || cmd_en_o !== 1'b0) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); else n_pass++;
        n_total++; if (evq.size() != 0) $display("FAIL bp_no_cmd: got %0d cmds want 0", evq.size()); else n_pass++;
        cmd_full_i = 1'b0;
        repeat (10) tick();
        n_total++; if (evq.size() != 1) $display("FAIL bp_release: got %0d cmds want 1", evq.size()); else n_pass++;
        if (evq.size() > 0) begin
            n_total++; if (evq[0].addr !== a || evq[0].wg !== 1'b1) $display("FAIL bp_cmd: got 0x%0h/gnt %0b want 0x%0h/1", evq[0].addr, evq[0].wg, a); else n_pass++;
        end
        n_total++; if (stray != 0 || wr_cmds_o !== 16'd1) $display("FAIL bp_single: got stray %0d wr_cmds %0d want 0/1", stray, wr_cmds_o); else n_pass++;
    endtask

    task automatic test_misalign();
        do_reset();
        calib_done_i = 1'b1;
        wr_addr_i = 30'h104; wr_fifo_count_i = 7'd64; wr_req_i = 1'b1;
        rd_addr_i = rand_aligned() | ADDR_W'($urandom_range(1, 255)); rd_fifo_count_i = 7'd0; rd_req_i = 1'b1;
        repeat (20) tick();
        n_total++; if (evq.size() != 0) $display("FAIL misalign_no_cmd: got %0d cmds want 0", evq.size()); else n_pass++;
        n_total++; if (err_align_o !== 1'b1) $display("FAIL misalign_err: got %0b want 1", err_align_o); else n_pass++;
        wr_req_i = 1'b0; rd_req_i = 1'b0;
        repeat (10) tick();
        n_total++; if (err_align_o !== 1'b1) $display("FAIL misalign_sticky: got %0b want 1", err_align_o); else n_pass++;
        do_reset();
        n_total++; if (err_align_o !== 1'b0) $display("FAIL misalign_reset: got %0b want 0", err_align_o); else n_pass++;
    endtask

    task automatic test_abort_reset();
        do_reset();
        calib_done_i = 1'b1;
        wr_addr_i = rand_aligned(); wr_fifo_count_i = 7'd64; wr_req_i = 1'b1;
        for (int i = 0; i < 20 && evq.size() == 0; i++) tick();
        repeat (3) tick();
        n_total++; if (wr_cmds_o !== 16'd1) $display("FAIL abort_first: got %0d want 1", wr_cmds_o); else n_pass++;
        wr_addr_i = rand_aligned(); wr_req_i = 1'b1; cmd_full_i = 1'b1;
        repeat (4) tick();
        n_total++; if (busy_o !== 1'b1) $display("FAIL abort_in_issue: got %0b want 1", busy_o); else n_pass++;
        calib_done_i = 1'b0;
        tick();
        n_total++; if (busy_o !== 1'b0) $display("FAIL abort_idle: got busy %0b want 0", busy_o); else n_pass++;
        cmd_full_i = 1'b0;
        repeat (10) tick();
        n_total++; if (evq.size() != 1 || stray != 0) $display("FAIL abort_discard: got %0d cmds stray %0d want 1/0", evq.size(), stray); else n_pass++;
        n_total++; if (wr_cmds_o !== 16'd1) $display("FAIL abort_stats_kept: got %0d want 1", wr_cmds_o); else n_pass++;
        calib_done_i = 1'b1; cmd_full_i = 1'b1;
        repeat (4) tick();
        n_total++; if (busy_o !== 1'b1) $display("FAIL rst_in_issue: got %0b want 1", busy_o); else n_pass++;
        reset_i = 1'b1;
        tick();
        n_total++; if (cmd_en_o !== 1'b0 || busy_o !== 1'b0 || wr_gnt_o !== 1'b0) $display("FAIL rst_outputs: got en %0b busy %0b gnt %0b want 0", cmd_en_o, busy_o, wr_gnt_o); else n_pass++;
        n_total++; if (wr_cmds_o !== '0 || rd_cmds_o !== '0) $display("FAIL rst_counters: got wr %0d rd %0d want 0", wr_cmds_o, rd_cmds_o); else n_pass++;
        n_total++; if (cmd_byte_addr_o !== '0 || cmd_instr_o !== 3'b000) $display("FAIL rst_cmd_regs: got 0x%0h/%03b want 0/000", cmd_byte_addr_o, cmd_instr_o); else n_pass++;
        reset_i = 1'b0; calib_done_i = 1'b0; wr_req_i = 1'b0; cmd_full_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_calib_gating();
        test_fifo_gating();
        test_starvation();
        test_backpressure();
        test_misalign();
        test_abort_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
